vga_sig_gen: RTL and testbench

VGA_SIG_GEN -- requirements
Module: vga_sig_gen

---
 rtl/vga_sig_gen.sv | 137 +++++++++++++
 tb/tb_vga_sig_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sig_gen.sv
// VGA 640x480@60 timing generator with 4x4 pixel-replicated, 1-bit frame
// buffer readout and per-frame foreground/background colour selection.
// The line/frame geometry is parameterised; the defaults give standard
// 800x525 VGA timing.
module vga_sig_gen #(
   parameter int unsigned PIX_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] CONFIG_COLOURS,
   input  logic        VGA_DATA,
   output logic [14:0] VGA_ADDR,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic [7:0]  VGA_COLOUR,
   output logic        FRAME_START
);

   localparam int unsigned PW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int unsigned CW       = 10;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_STOP  = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_STOP  = VS_START + V_SYNC;

   logic [PW-1:0] pre_q, pre_d;
   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic [14:0]   addr_q, addr_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic [7:0]    colour_q, colour_d;
   logic          fs_q, fs_d;
   logic [15:0]   act_q, act_d;

   logic pt_c;
   logic h_last_c;
   logic v_last_c;
   logic in_hsync_c;
   logic in_vsync_c;
   logic visible_c;

   // Decode of the current (pre-tick) counter position.
   always_comb begin
      pt_c       = (pre_q == PW'(PIX_DIV - 1));
      h_last_c   = (hcount_q == CW'(H_TOTAL - 1));
      v_last_c   = (vcount_q == CW'(V_TOTAL - 1));
      in_hsync_c = (hcount_q >= CW'(HS_START)) && (hcount_q < CW'(HS_STOP));
      in_vsync_c = (vcount_q >= CW'(VS_START)) && (vcount_q < CW'(VS_STOP));
      visible_c  = (hcount_q < CW'(H_VISIBLE)) && (vcount_q < CW'(V_VISIBLE));
   end

   // Next-state for prescaler, counters, address and the pixel pipeline.
   always_comb begin
      pre_d    = pre_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      addr_d   = addr_q;
      hs_d     = hs_q;
      vs_d     = vs_q;
      colour_d = colour_q;
      act_d    = act_q;
      fs_d     = 1'b0;

      if (pt_c) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + PW'(1);
      end

      if (pt_c) begin
         if (h_last_c) begin
            hcount_d = '0;
            if (v_last_c) begin
               vcount_d = '0;
               act_d    = CONFIG_COLOURS;
               fs_d     = 1'b1;
            end else begin
               vcount_d = vcount_q + CW'(1);
            end
         end else begin
            hcount_d = hcount_q + CW'(1);
         end

         addr_d = {vcount_d[8:2], hcount_d[9:2]};
         hs_d   = ~in_hsync_c;
         vs_d   = ~in_vsync_c;
         if (visible_c) begin
            colour_d = VGA_DATA ? act_q[15:8] : act_q[7:0];
         end else begin
            colour_d = 8'h00;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pre_q    <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         addr_q   <= '0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         colour_q <= 8'h00;
         fs_q     <= 1'b0;
         act_q    <= 16'h0000;
      end else begin
         pre_q    <= pre_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         addr_q   <= addr_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         colour_q <= colour_d;
         fs_q     <= fs_d;
         act_q    <= act_d;
      end
   end

   assign VGA_ADDR    = addr_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_COLOUR  = colour_q;
   assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_sig_gen.sv
// Bench for vga_sig_gen: a reduced-geometry instance (PIX_DIV=2, 56x31
// frame) exercises frame wraps and colour latching, and a default
// instance (PIX_DIV=4, 800x525) checks real VGA line timing. Expected
// outputs come from the elapsed clock count since reset release.
module tb_vga_sig_gen;

   typedef struct packed {
      logic [14:0] addr;
      logic        hs;
      logic        vs;
      logic        vis;
      logic [14:0] paddr;
      logic        fs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cfg = 16'hE01C;
   logic        data_i [2];
   logic [14:0] addr_o [2];
   logic        hs_o   [2];
   logic        vs_o   [2];
   logic [7:0]  col_o  [2];
   logic        fs_o   [2];

   logic        fb [32768];
   logic [15:0] act [2];
   logic [15:0] cfg_edge;
   int unsigned e;
   int          vectors = 0;
   int          miscompares = 0;
   int          phase = 0;

   always #5 clk = ~clk;

   vga_sig_gen #(
      .PIX_DIV(2), .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_VISIBLE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_small (
      .CLK(clk), .RESET(rst), .CONFIG_COLOURS(cfg), .VGA_DATA(data_i[0]),
      .VGA_ADDR(addr_o[0]), .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0]),
      .VGA_COLOUR(col_o[0]), .FRAME_START(fs_o[0])
   );

   vga_sig_gen dut_vga (
      .CLK(clk), .RESET(rst), .CONFIG_COLOURS(cfg), .VGA_DATA(data_i[1]),
      .VGA_ADDR(addr_o[1]), .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1]),
      .VGA_COLOUR(col_o[1]), .FRAME_START(fs_o[1])
   );

   // Frame buffer read ports: one CLK of latency.
   always_ff @(posedge clk) begin
      data_i[0] <= fb[addr_o[0]];
      data_i[1] <= fb[addr_o[1]];
   end

   function automatic logic [14:0] mkaddr(input int unsigned h, input int unsigned v);
      logic [9:0] hb;
      logic [9:0] vb;
      hb = 10'(h);
      vb = 10'(v);
      return {vb[8:2], hb[9:2]};
   endfunction

   // Expected outputs after clock edge e (counted from reset release).
   function automatic exp_t model(input int d, input int unsigned ecount);
      int unsigned p, hv, hfp, hsy, hbp, vv, vfp, vsy, vbp;
      int unsigned ht, ft, m, pos, ppos, ph, pv;
      exp_t r;
      if (d == 0) begin
         p = 2; hv = 40; hfp = 4; hsy = 8; hbp = 4;
         vv = 24; vfp = 2; vsy = 2; vbp = 3;
      end else begin
         p = 4; hv = 640; hfp = 16; hsy = 96; hbp = 48;
         vv = 480; vfp = 10; vsy = 2; vbp = 33;
      end
      ht   = hv + hfp + hsy + hbp;
      ft   = ht * (vv + vfp + vsy + vbp);
      m    = ecount / p;
      pos  = m % ft;
      ppos = (pos + ft - 1) % ft;
      ph   = ppos % ht;
      pv   = ppos / ht;
      r.addr  = mkaddr(pos % ht, pos / ht);
      r.paddr = mkaddr(ph, pv);
      r.hs    = !(m > 0 && ph >= hv + hfp && ph < hv + hfp + hsy);
      r.vs    = !(m > 0 && pv >= vv + vfp && pv < vv + vfp + vsy);
      r.vis   = (m > 0) && (ph < hv) && (pv < vv);
      r.fs    = (ecount % p == 0) && (m > 0) && (pos == 0);
      return r;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] got,
                      input logic [31:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, d, e, got, expv);
      end
   endtask

   task automatic chk_reset_state(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_addr"}, d, 32'(addr_o[d]), 32'd0);
         chk({nm, "_hs"},   d, 32'(hs_o[d]),   32'd1);
         chk({nm, "_vs"},   d, 32'(vs_o[d]),   32'd1);
         chk({nm, "_col"},  d, 32'(col_o[d]),  32'd0);
         chk({nm, "_fs"},   d, 32'(fs_o[d]),   32'd0);
      end
   endtask

   // Hand-computed points that pin the model.
   task automatic chk_literals();
      logic [14:0] a;
      if (e == 15) chk("lit_first_pt_early", 1, 32'(addr_o[1]), 32'd0);
      if (e == 16) chk("lit_first_addr_step", 1, 32'(addr_o[1]), 32'd1);
      if (e == 2624) chk("lit_hs_before", 1, 32'(hs_o[1]), 32'd1);
      if (e == 2628) chk("lit_hs_fall", 1, 32'(hs_o[1]), 32'd0);
      if (e == 3008) chk("lit_hs_last_low", 1, 32'(hs_o[1]), 32'd0);
      if (e == 3012) chk("lit_hs_rise", 1, 32'(hs_o[1]), 32'd1);
      if (e == 2654) begin
         a = {7'd5, 8'd9};
         chk("lit_addr_last_vis", 0, 32'(addr_o[0]), 32'(a));
      end
      if (e == 3470) begin
         a = {7'd7, 8'd13};
         chk("lit_addr_frame_end", 0, 32'(addr_o[0]), 32'(a));
      end
      if (e == 3472) begin
         chk("lit_addr_wrap", 0, 32'(addr_o[0]), 32'd0);
         chk("lit_fs_pulse", 0, 32'(fs_o[0]), 32'd1);
         chk("lit_col_blank", 0, 32'(col_o[0]), 32'd0);
      end
      if (e == 3473) chk("lit_fs_one_clk", 0, 32'(fs_o[0]), 32'd0);
      if (e == 3474) chk("lit_col_first_fg", 0, 32'(col_o[0]), 32'hE0);
   endtask

   // One CLK: capture the inputs seen at the edge, then compare mid-cycle.
   task automatic step();
      exp_t x;
      logic [7:0] ecol;
      @(posedge clk);
      cfg_edge = cfg;
      e++;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         x = model(d, e);
         if (x.fs) act[d] = cfg_edge;
         if (x.vis) ecol = fb[x.paddr] ? act[d][15:8] : act[d][7:0];
         else       ecol = 8'h00;
         chk("addr", d, 32'(addr_o[d]), 32'(x.addr));
         chk("hs",   d, 32'(hs_o[d]),   32'(x.hs));
         chk("vs",   d, 32'(vs_o[d]),   32'(x.vs));
         chk("col",  d, 32'(col_o[d]),  32'(ecol));
         chk("fs",   d, 32'(fs_o[d]),   32'(x.fs));
      end
      if (phase == 1) chk_literals();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk_reset_state("rst_async");
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("rst_held");
      rst = 1'b0;
      e = 0;
      act[0] = 16'h0000;
      act[1] = 16'h0000;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) fb[i] = ($urandom_range(0, 3) == 0);
      fb[0] = 1'b1;
      e = 0;

      #2;
      do_reset();

      phase = 1;
      for (int i = 0; i < 8000; i++) begin
         if (e == 5200) cfg = 16'h03FF;
         step();
      end

      phase = 2;
      do_reset();
      for (int i = 0; i < 7200; i++) begin
         if ($urandom_range(0, 299) == 0) cfg = 16'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
